// File: rtl/cntl_mc_hs.sv
// Multi-cycle RV32I control unit: sequences fetch, decode, execute, memory and writeback,
// with memory-wait timeouts, an optional M-extension handshake and a retired-instruction counter.
module cntl_mc_hs #(
  parameter int ALU_CTRL_WIDTH    = 5,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int TIMEOUT_CYCLES    = 15,
  parameter int ENABLE_M          = 1,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  input  logic                         bcond,
  input  logic                         mem_ready,
  input  logic                         mext_done,
  input  logic                         trap_ack,
  output logic                         mem_req,
  output logic                         i_d_mem,
  output logic                         mem_r,
  output logic                         mem_w,
  output logic                         op1_sel,
  output logic [1:0]                   op2_sel,
  output logic [1:0]                   alu_demux,
  output logic                         wr_reg_mux,
  output logic                         wr_en,
  output logic                         load_ir,
  output logic                         pc_update,
  output logic                         load_mdr,
  output logic [ALU_CTRL_WIDTH-1:0]    alu_ctrl,
  output logic [1:0]                   mem_size,
  output logic                         mext_start,
  output logic                         trap,
  output logic [1:0]                   trap_cause,
  output logic [CNT_WIDTH-1:0]         instret
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXEC      = 3'd2,
    S_MEM       = 3'd3,
    S_MEXT_WAIT = 3'd4,
    S_WB        = 3'd5,
    S_ALU2PC    = 3'd6,
    S_TRAP      = 3'd7
  } state_t;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_IMM    = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd0;
  localparam logic [1:0] CAUSE_FETCH   = 2'd1;
  localparam logic [1:0] CAUSE_DATA    = 2'd2;
  localparam logic [7:0] TIMEOUT_LIM   = 8'(TIMEOUT_CYCLES);

  state_t                      state_reg, state_next;
  logic [7:0]                  wait_cnt_reg, wait_cnt_next;
  logic [CNT_WIDTH-1:0]        instret_reg, instret_next;
  logic [1:0]                  trap_cause_reg, trap_cause_next;
  logic [ALU_CTRL_WIDTH-1:0]   alu_ctrl_reg;
  logic [1:0]                  mem_size_reg;
  logic                        retire, timeout;

  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_load, is_store, is_branch, is_jump, is_muldiv, is_known, is_legal;
  logic [4:0] alu_code;
  logic [1:0] size_code;
  logic       unused_instr_bits;

  assign opcode            = instruction[6:2];
  assign funct3            = instruction[14:12];
  assign funct7            = instruction[31:25];
  assign unused_instr_bits = ^instruction;

  // Instruction class decode; IR is stable from DECODE until the next fetch.
  always_comb begin
    is_load   = (opcode == OPC_LOAD);
    is_store  = (opcode == OPC_STORE);
    is_branch = (opcode == OPC_BRANCH);
    is_jump   = (opcode == OPC_JAL) || (opcode == OPC_JALR);
    is_muldiv = (opcode == OPC_OP) && (funct7 == 7'b0000001);
    is_known  = is_load || is_store || is_branch || is_jump ||
                (opcode == OPC_IMM) || (opcode == OPC_OP) ||
                (opcode == OPC_LUI) || (opcode == OPC_AUIPC);
    is_legal  = (instruction[1:0] == 2'b11) && is_known &&
                !(is_muldiv && (ENABLE_M == 0));
  end

  always_comb begin
    alu_code  = 5'b00000;
    size_code = 2'b00;
    case (opcode)
      OPC_OP:     alu_code = {1'b0, instruction[30], funct3};
      OPC_IMM:    alu_code = ((funct3 == 3'b010) || (funct3 == 3'b011)) ?
                             {2'b01, funct3} : {2'b00, funct3};
      OPC_LOAD,
      OPC_STORE:  size_code = instruction[13:12];
      OPC_BRANCH: alu_code = {2'b10, funct3};
      OPC_LUI:    alu_code = 5'b11000;
      OPC_JALR:   alu_code = opcode;
      default:    alu_code = 5'b00000;
    endcase
  end

  // State register plus the counters that advance alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_FETCH;
      wait_cnt_reg   <= '0;
      instret_reg    <= '0;
      trap_cause_reg <= CAUSE_ILLEGAL;
      alu_ctrl_reg   <= '0;
      mem_size_reg   <= 2'b00;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      instret_reg    <= instret_next;
      trap_cause_reg <= trap_cause_next;
      if (state_reg == S_DECODE) begin
        alu_ctrl_reg <= ALU_CTRL_WIDTH'(alu_code);
        mem_size_reg <= size_code;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    trap_cause_next = trap_cause_reg;
    retire          = 1'b0;
    // mem_ready is tested first, so a completion on the limit cycle beats the timeout.
    timeout         = (wait_cnt_reg + 8'd1) >= TIMEOUT_LIM;
    case (state_reg)
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next      = S_TRAP;
          trap_cause_next = CAUSE_FETCH;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_next = S_EXEC;
        end else begin
          state_next      = S_TRAP;
          trap_cause_next = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          state_next = bcond ? S_ALU2PC : S_FETCH;
          retire     = !bcond;
        end else if (is_jump) begin
          state_next = S_ALU2PC;
        end else if (is_load || is_store) begin
          state_next = S_MEM;
        end else if (is_muldiv) begin
          state_next = S_MEXT_WAIT;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_next = is_load ? S_WB : S_FETCH;
          retire     = !is_load;
        end else if (timeout) begin
          state_next      = S_TRAP;
          trap_cause_next = CAUSE_DATA;
        end
      end
      S_MEXT_WAIT: if (mext_done) state_next = S_WB;
      S_WB: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_ALU2PC: begin
        state_next = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP: if (trap_ack) state_next = S_FETCH;
      default: state_next = S_FETCH;
    endcase

    if ((state_next == state_reg) && ((state_reg == S_FETCH) || (state_reg == S_MEM)))
      wait_cnt_next = wait_cnt_reg + 8'd1;
    else
      wait_cnt_next = '0;

    instret_next = retire ? (instret_reg + CNT_WIDTH'(1)) : instret_reg;
  end

  always_comb begin
    mem_req    = 1'b0;
    i_d_mem    = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    op1_sel    = 1'b0;
    op2_sel    = 2'd0;
    alu_demux  = 2'd0;
    wr_reg_mux = 1'b0;
    wr_en      = 1'b0;
    load_ir    = 1'b0;
    pc_update  = 1'b0;
    load_mdr   = 1'b0;
    mext_start = 1'b0;
    trap       = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_r     = 1'b1;
        // Strobes stay low while reset holds the FSM in FETCH.
        load_ir   = mem_ready & rst;
        pc_update = mem_ready & rst;
      end
      S_EXEC: begin
        // op1: 1 = PC; op2: 1 = immediate; demux: 1 = PC target, 2 = memory address.
        op1_sel    = (opcode == OPC_AUIPC) || (opcode == OPC_JAL);
        op2_sel    = ((opcode == OPC_OP) || is_branch) ? 2'd0 : 2'd1;
        alu_demux  = (is_jump || is_branch) ? 2'd1 : ((is_load || is_store) ? 2'd2 : 2'd0);
        wr_en      = is_jump;
        mext_start = is_muldiv && (ENABLE_M != 0);
      end
      S_MEM: begin
        mem_req  = 1'b1;
        i_d_mem  = 1'b1;
        mem_r    = is_load;
        mem_w    = is_store;
        load_mdr = is_load & mem_ready;
      end
      S_WB: begin
        wr_en      = 1'b1;
        wr_reg_mux = is_load;
      end
      S_ALU2PC: pc_update = 1'b1;
      S_TRAP:   trap      = 1'b1;
      default: ;
    endcase
  end

  assign alu_ctrl   = alu_ctrl_reg;
  assign mem_size   = mem_size_reg;
  assign trap_cause = trap_cause_reg;
  assign instret    = instret_reg;

endmodule

// File: tb/tb_cntl_mc_hs.sv
// Randomized self-checking bench for cntl_mc_hs: a transaction-level model predicts each
// instruction's cycle path, strobes, decode results, traps and the retire count.
module tb_cntl_mc_hs;
  localparam int TO = 15;

  typedef enum int {C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_IMM, C_OP, C_LUI, C_AUIPC,
                    C_MUL, C_ILL} cls_e;

  logic        clk, rst, bcond, mem_ready, mext_done, trap_ack;
  logic [31:0] instruction;

  logic       mem_req, i_d_mem, mem_r, mem_w, op1_sel, wr_reg_mux, wr_en, load_ir;
  logic       pc_update, load_mdr, mext_start, trap;
  logic [1:0] op2_sel, alu_demux, mem_size, trap_cause;
  logic [4:0] alu_ctrl;
  logic [3:0] instret;

  logic       d1_mem_req, d1_i_d_mem, d1_mem_r, d1_mem_w, d1_op1_sel, d1_wr_reg_mux, d1_wr_en;
  logic       d1_load_ir, d1_pc_update, d1_load_mdr, d1_mext_start, d1_trap;
  logic [1:0] d1_op2_sel, d1_alu_demux, d1_mem_size, d1_trap_cause;
  logic [4:0] d1_alu_ctrl;
  logic [3:0] d1_instret;

  int         n_checks = 0;
  int         n_errors = 0;
  int         n_txn = 0;
  logic [3:0] exp_instret = 4'd0;

  cntl_mc_hs #(.ALU_CTRL_WIDTH(5), .INSTRUCTION_WIDTH(32), .TIMEOUT_CYCLES(TO),
               .ENABLE_M(1), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .bcond(bcond), .mem_ready(mem_ready),
    .mext_done(mext_done), .trap_ack(trap_ack), .mem_req(mem_req), .i_d_mem(i_d_mem),
    .mem_r(mem_r), .mem_w(mem_w), .op1_sel(op1_sel), .op2_sel(op2_sel), .alu_demux(alu_demux),
    .wr_reg_mux(wr_reg_mux), .wr_en(wr_en), .load_ir(load_ir), .pc_update(pc_update),
    .load_mdr(load_mdr), .alu_ctrl(alu_ctrl), .mem_size(mem_size), .mext_start(mext_start),
    .trap(trap), .trap_cause(trap_cause), .instret(instret));

  cntl_mc_hs #(.ALU_CTRL_WIDTH(5), .INSTRUCTION_WIDTH(32), .TIMEOUT_CYCLES(TO),
               .ENABLE_M(0), .CNT_WIDTH(4)) dut_nom (
    .clk(clk), .rst(rst), .instruction(instruction), .bcond(bcond), .mem_ready(mem_ready),
    .mext_done(mext_done), .trap_ack(trap_ack), .mem_req(d1_mem_req), .i_d_mem(d1_i_d_mem),
    .mem_r(d1_mem_r), .mem_w(d1_mem_w), .op1_sel(d1_op1_sel), .op2_sel(d1_op2_sel),
    .alu_demux(d1_alu_demux), .wr_reg_mux(d1_wr_reg_mux), .wr_en(d1_wr_en),
    .load_ir(d1_load_ir), .pc_update(d1_pc_update), .load_mdr(d1_load_mdr),
    .alu_ctrl(d1_alu_ctrl), .mem_size(d1_mem_size), .mext_start(d1_mext_start),
    .trap(d1_trap), .trap_cause(d1_trap_cause), .instret(d1_instret));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cls_e classify(input logic [31:0] ins);
    if (ins[1:0] != 2'b11) return C_ILL;
    case (ins[6:2])
      5'b00000: return C_LOAD;
      5'b01000: return C_STORE;
      5'b11000: return C_BR;
      5'b11011: return C_JAL;
      5'b11001: return C_JALR;
      5'b00100: return C_IMM;
      5'b01100: return (ins[31:25] == 7'b0000001) ? C_MUL : C_OP;
      5'b01101: return C_LUI;
      5'b00101: return C_AUIPC;
      default:  return C_ILL;
    endcase
  endfunction

  function automatic logic [4:0] exp_alu(input logic [31:0] ins, input cls_e c);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (c)
      C_OP, C_MUL: return {1'b0, ins[30], f3};
      C_IMM:       return ((f3 == 3'd2) || (f3 == 3'd3)) ? {2'b01, f3} : {2'b00, f3};
      C_BR:        return {2'b10, f3};
      C_LUI:       return 5'b11000;
      C_JALR:      return 5'b11001;
      default:     return 5'b00000;
    endcase
  endfunction

  function automatic logic [31:0] make_instr(input cls_e c);
    logic [31:0] r;
    logic [4:0]  op;
    r = $urandom;
    case (c)
      C_LOAD:      op = 5'b00000;
      C_STORE:     op = 5'b01000;
      C_BR:        op = 5'b11000;
      C_JAL:       op = 5'b11011;
      C_JALR:      op = 5'b11001;
      C_IMM:       op = 5'b00100;
      C_OP, C_MUL: op = 5'b01100;
      C_LUI:       op = 5'b01101;
      C_AUIPC:     op = 5'b00101;
      default:     op = 5'b00000;
    endcase
    r[6:2] = op;
    r[1:0] = 2'b11;
    if (c == C_OP)  r[31:25] = r[31] ? 7'h20 : 7'h00;
    if (c == C_MUL) r[31:25] = 7'h01;
    if (c == C_ILL) begin
      if (r[7]) begin
        r[1:0] = 2'($urandom_range(0, 2));
      end else begin
        do op = 5'($urandom); while (classify({25'd0, op, 2'b11}) != C_ILL);
        r[6:2] = op;
      end
    end
    return r;
  endfunction

  task automatic log_txn(input logic [31:0] ins, input cls_e c, input int fw, input int mw,
                         input string outcome);
    n_txn++;
    $display("txn %0d %s instr=%08h fetch_wait=%0d mem_wait=%0d -> %s instret=%0d",
             n_txn, c.name(), ins, fw, mw, outcome, instret);
  endtask

  // Entered at a falling edge with the FSM already in TRAP.
  task automatic take_trap(input logic [1:0] cause);
    int hold;
    hold = int'($urandom_range(0, 3));
    trap_ack = 1'b0;
    for (int i = 0; i < hold; i++) begin
      mem_ready = 1'($urandom);
      mext_done = 1'($urandom);
      #1;
      check("trap_hold", 32'({trap, mem_req, wr_en, load_ir, pc_update, load_mdr, mext_start}),
            32'(7'b1000000));
      check("trap_cause", 32'(trap_cause), 32'(cause));
      @(negedge clk);
    end
    mem_ready = 1'b0;
    mext_done = 1'b0;
    trap_ack  = 1'b1;
    #1;
    check("trap_ack_cycle", 32'({trap, trap_cause}), 32'({1'b1, cause}));
    @(negedge clk);
    trap_ack = 1'b0;
    check("trap_exit", 32'({trap, mem_req, mem_r}), 32'(3'b011));
    check("trap_instret", 32'(instret), 32'(exp_instret));
  endtask

  // One instruction from FETCH back to FETCH (or through TRAP); starts and ends at a falling edge.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic bc,
                           input int xw);
    cls_e c;
    logic ld;
    c  = classify(ins);
    ld = (c == C_LOAD);
    instruction = ins;
    trap_ack = 1'b0; mext_done = 1'b0; bcond = 1'b0;
    for (int i = 0; i < fw && i < TO; i++) begin
      mem_ready = 1'b0;
      #1;
      check("fetch_wait", 32'({mem_req, mem_r, i_d_mem, load_ir, pc_update, trap}),
            32'(6'b110000));
      @(negedge clk);
    end
    if (fw >= TO) begin
      take_trap(2'd1);
      log_txn(ins, c, fw, mw, "fetch_timeout");
      return;
    end
    mem_ready = 1'b1;
    #1;
    check("fetch_done", 32'({mem_req, mem_r, i_d_mem, load_ir, pc_update}), 32'(5'b11011));
    @(negedge clk);
    mem_ready = 1'b0;
    mext_done = 1'($urandom);
    bcond     = 1'($urandom);
    #1;
    check("decode_idle", 32'({mem_req, wr_en, load_ir, pc_update, trap, mext_start}), 32'(0));
    @(negedge clk);
    mext_done = 1'b0;
    if (c == C_ILL) begin
      take_trap(2'd0);
      log_txn(ins, c, fw, mw, "illegal");
      return;
    end
    check("alu_ctrl", 32'(alu_ctrl), 32'(exp_alu(ins, c)));
    check("mem_size", 32'(mem_size), 32'(((c == C_LOAD) || (c == C_STORE)) ? ins[13:12] : 2'b00));
    bcond = bc;
    #1;
    case (c)
      C_BR: begin
        check("exec_branch", 32'({wr_en, mem_req, pc_update, mext_start}), 32'(0));
        @(negedge clk);
        bcond = 1'b0;
        if (bc) begin
          #1;
          check("branch_alu2pc", 32'({pc_update, wr_en, mem_req}), 32'(3'b100));
          @(negedge clk);
        end
      end
      C_JAL, C_JALR: begin
        check("exec_link", 32'({wr_en, wr_reg_mux, mem_req, pc_update}), 32'(4'b1000));
        @(negedge clk);
        #1;
        check("jump_alu2pc", 32'({pc_update, wr_en, mem_req}), 32'(3'b100));
        @(negedge clk);
      end
      C_LOAD, C_STORE: begin
        check("exec_ls", 32'({wr_en, mem_req, mext_start}), 32'(0));
        @(negedge clk);
        for (int i = 0; i < mw && i < TO; i++) begin
          mem_ready = 1'b0;
          #1;
          check("mem_wait", 32'({mem_req, i_d_mem, mem_r, mem_w, load_mdr, trap}),
                32'({1'b1, 1'b1, ld, !ld, 1'b0, 1'b0}));
          @(negedge clk);
        end
        if (mw >= TO) begin
          take_trap(2'd2);
          log_txn(ins, c, fw, mw, "data_timeout");
          return;
        end
        mem_ready = 1'b1;
        #1;
        check("mem_done", 32'({mem_req, i_d_mem, mem_r, mem_w, load_mdr}),
              32'({1'b1, 1'b1, ld, !ld, ld}));
        @(negedge clk);
        mem_ready = 1'b0;
        if (ld) begin
          #1;
          check("wb_load", 32'({wr_en, wr_reg_mux, mem_req}), 32'(3'b110));
          @(negedge clk);
        end
      end
      C_MUL: begin
        check("exec_mext_start", 32'({mext_start, wr_en}), 32'(2'b10));
        @(negedge clk);
        bcond = 1'b0;
        for (int i = 0; i < xw; i++) begin
          mem_ready = 1'($urandom);
          #1;
          check("mext_wait", 32'({mext_start, wr_en, mem_req, trap}), 32'(0));
          @(negedge clk);
        end
        mem_ready = 1'b0;
        mext_done = 1'b1;
        #1;
        check("mext_done_cycle", 32'({wr_en, mext_start}), 32'(0));
        @(negedge clk);
        mext_done = 1'b0;
        #1;
        check("wb_mext", 32'({wr_en, wr_reg_mux}), 32'(2'b10));
        @(negedge clk);
      end
      default: begin
        check("exec_alu", 32'({wr_en, mem_req, mext_start, pc_update}), 32'(0));
        @(negedge clk);
        #1;
        check("wb_alu", 32'({wr_en, wr_reg_mux, mem_req}), 32'(3'b100));
        @(negedge clk);
      end
    endcase
    bcond = 1'b0;
    exp_instret = exp_instret + 4'd1;
    check("retire_instret", 32'(instret), 32'(exp_instret));
    check("retire_fetch", 32'({mem_req, mem_r, trap}), 32'(3'b110));
    log_txn(ins, c, fw, mw, "retired");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_fetch", 32'({mem_req, mem_r, trap, instret}), 32'({3'b110, 4'd0}));
    @(negedge clk);
    rst = 1'b1;
    exp_instret = 4'd0;
  endtask

  localparam logic [31:0] I_ADD = 32'h003100B3;
  localparam logic [31:0] I_LW  = 32'h00012083;
  localparam logic [31:0] I_BEQ = 32'h00208063;
  localparam logic [31:0] I_MUL = 32'h022081B3;

  initial begin
    int fw, mw;
    cls_e c;
    rst = 1'b1; bcond = 1'b0; mem_ready = 1'b1; mext_done = 1'b0; trap_ack = 1'b0;
    instruction = I_ADD;
    #1 rst = 1'b0;
    #2;
    check("rst_mem", 32'({mem_req, mem_r, i_d_mem, mem_w}), 32'(4'b1100));
    check("rst_strobes", 32'({wr_en, wr_reg_mux, load_ir, pc_update, load_mdr, mext_start, trap}),
          32'(0));
    check("rst_sels", 32'({op1_sel, op2_sel, alu_demux}), 32'(0));
    check("rst_regs", 32'({alu_ctrl, mem_size, trap_cause, instret}), 32'(0));
    @(negedge clk);
    @(negedge clk);
    check("rst_held_strobes", 32'({load_ir, pc_update, instret}), 32'(0));
    mem_ready = 1'b0;
    rst = 1'b1;

    // MUL with and without the M extension.
    instruction = I_MUL;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("m_enabled_start", 32'({mext_start, trap}), 32'(2'b10));
    check("m_disabled_trap", 32'({d1_trap, d1_trap_cause, d1_mext_start}), 32'(4'b1000));
    pulse_reset();

    run_instr(I_ADD, 0, 0, 1'b0, 0);
    run_instr(I_LW, 0, 3, 1'b0, 0);
    run_instr(I_BEQ, 1, 0, 1'b0, 0);
    run_instr(I_BEQ, 0, 0, 1'b1, 0);
    run_instr(I_ADD, TO, 0, 1'b0, 0);
    run_instr(I_ADD, TO - 1, 0, 1'b0, 0);
    run_instr(make_instr(C_STORE), 0, TO - 1, 1'b0, 0);
    run_instr(make_instr(C_STORE), 0, TO, 1'b0, 0);
    run_instr(I_MUL, 0, 0, 1'b0, 20);
    run_instr(32'h003100B1, 0, 0, 1'b0, 0);

    for (int n = 0; n < 150; n++) begin
      c  = cls_e'($urandom_range(0, 10));
      fw = int'($urandom_range(0, 15));
      fw = (fw == 0) ? TO : ((fw == 1) ? TO - 1 : int'($urandom_range(0, 3)));
      mw = int'($urandom_range(0, 15));
      mw = (mw == 0) ? TO : ((mw == 1) ? TO - 1 : int'($urandom_range(0, 4)));
      run_instr(make_instr(c), fw, mw, 1'($urandom), int'($urandom_range(0, 20)));
    end

    // Asynchronous reset in the middle of a data access.
    if (exp_instret == 4'd0) run_instr(I_ADD, 0, 0, 1'b0, 0);
    instruction = I_LW;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre_reset_mem", 32'({mem_req, i_d_mem, mem_r, mem_size}), 32'(5'b11110));
    #2 rst = 1'b0;
    #1;
    check("async_rst_mem", 32'({mem_req, mem_r, i_d_mem, mem_w, load_mdr, wr_en}),
          32'(6'b110000));
    check("async_rst_regs", 32'({alu_ctrl, mem_size, trap_cause, instret}), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    exp_instret = 4'd0;

    // Sixteen retires from zero: the last one wraps the 4-bit counter back to 0.
    for (int n = 0; n < 16; n++) run_instr(I_ADD, 0, 0, 1'b0, 0);
    check("instret_wrapped", 32'(instret), 32'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cntl_mc_hs.md
CNTL_MC_HS -- requirements
Module: cntl_mc_hs

Interface
REQ-001 Parameter ALU_CTRL_WIDTH, default 5: width of alu_ctrl.
REQ-002 Parameter INSTRUCTION_WIDTH, default 32: width of instruction.
REQ-003 Parameter TIMEOUT_CYCLES, default 15: maximum memory-wait cycles before trap; legal range 1..255.
REQ-004 Parameter ENABLE_M, default 1: 1 enables the multi-cycle M-extension path; 0 makes M opcodes illegal.
REQ-005 Parameter CNT_WIDTH, default 32: width of instret.
REQ-006 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 instruction  in  INSTRUCTION_WIDTH  IR contents; valid from DECODE onward.
REQ-010 bcond  in  1  branch-taken flag from ALU; sampled in EXEC.
REQ-011 mem_ready  in  1  memory completes the current request this cycle.
REQ-012 mext_done  in  1  multiply/divide unit result valid, single-cycle pulse.
REQ-013 trap_ack  in  1  trap handler acknowledge.
REQ-014 mem_req, i_d_mem, mem_r, mem_w  out  1 each  request, 0=instr/1=data space, read, write.
REQ-015 op1_sel  out  1  and op2_sel, alu_demux  out  2 each  datapath operand/result selects.
REQ-016 wr_reg_mux, wr_en, load_ir, pc_update, load_mdr  out  1 each  datapath strobes.
REQ-017 alu_ctrl  out  ALU_CTRL_WIDTH; mem_size  out  2  registered decode results.
REQ-018 mext_start  out  1; trap  out  1; trap_cause  out  2 (0 illegal, 1 fetch timeout, 2 data timeout); instret  out  CNT_WIDTH.

Function
REQ-019 States: FETCH, DECODE, EXEC, MEM, MEXT_WAIT, WB, ALU2PC, TRAP; held in one state register.
REQ-020 FETCH: mem_req=1, mem_r=1, i_d_mem=0; with mem_ready=1, load_ir=1 and pc_update=1 for that cycle, next DECODE; otherwise stay.
REQ-021 DECODE: alu_ctrl and mem_size are registered from instruction using the existing RV32I encoding (R {0,inst[30],funct3}; SLTI/SLTIU {01,funct3}; other I {00,funct3}; load/store 0 with mem_size=inst[13:12]; branch {10,funct3}; LUI 11000; JALR inst[6:2]).
REQ-022 DECODE: if inst[1:0]!=2'b11, opcode not in the nine RV32I classes, or R-type funct7=0000001 with ENABLE_M=0, next TRAP with trap_cause=0; otherwise next EXEC.
REQ-023 EXEC BRANCH: bcond=1 -> ALU2PC, bcond=0 -> FETCH (retires).
REQ-024 EXEC JAL/JALR: wr_en=1 (link write, wr_reg_mux=0), next ALU2PC.
REQ-025 EXEC LOAD/STORE: next MEM; LUI/AUIPC/I/R: next WB; R-type funct7=0000001 with ENABLE_M=1: mext_start=1 for that single cycle, next MEXT_WAIT.
REQ-026 MEM: mem_req=1, i_d_mem=1, mem_r=1 for loads or mem_w=1 for stores; on mem_ready a load asserts load_mdr=1 and goes to WB, a store goes to FETCH (retires).
REQ-027 MEXT_WAIT: hold until mext_done=1, then WB; no timeout applies; mext_done in any other state is ignored.
REQ-028 WB: wr_en=1, wr_reg_mux=1 for loads else 0; next FETCH (retires).
REQ-029 ALU2PC: pc_update=1; next FETCH (retires).
REQ-030 Wait counter: cleared on entry to FETCH or MEM, increments each cycle in them with mem_ready=0; reaching TIMEOUT_CYCLES -> TRAP, trap_cause=1 (FETCH) or 2 (MEM); mem_ready in the same cycle as the limit wins (no trap).
REQ-031 TRAP: trap=1, all strobes and mem_req 0; held until trap_ack=1, then FETCH; trap does not increment instret.
REQ-032 instret increments by 1 on each retire transition listed above; wraps from all-ones to 0 with no flag.
REQ-033 Outputs not asserted by the current state are 0; select outputs are 0 unless state-driven (no X outputs).

Reset
REQ-034 rst=0 asynchronously forces FETCH, wait counter 0, instret 0, alu_ctrl 0, mem_size 0, trap_cause 0; all outputs 0 except mem_req=1 and mem_r=1 from FETCH decode.
REQ-035 Reset asserted mid-instruction (including MEM, MEXT_WAIT, TRAP) abandons it without retire; first post-release edge evaluates FETCH.

Verification
REQ-036 ADD x1,x2,x3 with mem_ready=1 in FETCH -> FETCH, DECODE, EXEC, WB, FETCH; wr_en=1 only in WB; alu_ctrl=00000; instret 0->1.
REQ-037 LW with data mem_ready delayed 3 cycles -> MEM held 4 cycles, load_mdr=1 on the ready cycle, WB wr_reg_mux=1, mem_size=10.
REQ-038 BEQ with bcond=0 -> FETCH after EXEC, instret+1; bcond=1 -> ALU2PC with pc_update=1, alu_ctrl=10000.
REQ-039 Fetch with mem_ready held 0, TIMEOUT_CYCLES=15 -> TRAP after 15 wait cycles, trap_cause=1; trap_ack -> FETCH, instret unchanged.
REQ-040 MUL (funct7=0000001): ENABLE_M=1 -> mext_start one cycle, MEXT_WAIT until mext_done, WB; ENABLE_M=0 -> TRAP cause 0; instruction[1:0]=01 -> TRAP cause 0.
REQ-041 instret preset to all-ones via 2^CNT_WIDTH-1 retires (CNT_WIDTH=4) -> next retire gives 0; rst=0 pulsed mid-MEM -> outputs at reset values immediately, no clock needed.
